mc_cpu_core_hs: RTL and testbench

Parametrised multi-cycle MIPS-subset core with a valid/ready memory handshake, so instruction and data memory may take a variable number of cycles.
- Internal 32x32 register file, IR, MDR, A/B/ALUOut temporaries, single shared ALU and a one-hot-safe control FSM, all in one block.
- Sits between the board top level and a unified instruction/data memory or bus bridge.
- Adds to the prior multi-cycle design: memory wait states, configurable reset vector, illegal/misaligned/timeout trapping to a sticky halt, and a retire pulse.

---
 rtl/mc_cpu_core_hs.sv | 366 ++++++++++++++++++++++++++++++++++++
 tb/tb_mc_cpu_core_hs.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_cpu_core_hs.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : mc_cpu_core_hs
// Purpose  : Multi-cycle MIPS-subset core (addu/subu/and/or/slt/jr, j, jal,
//            beq, addiu, lui, lw, sw) with a valid/ready memory handshake
//            to a unified instruction/data memory. Illegal instructions,
//            misaligned lw/sw addresses and memory timeouts all stop the
//            core in a sticky HALT state that holds until reset.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   RESET_PC      PC loaded on reset (word-aligned)
//   WAIT_TIMEOUT  max unacknowledged request cycles before halt, 0 = never
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   mem_req/we/addr/wdata  request side, held until mem_ready
//   mem_ready/rdata     completion and read data from memory
//   pc_out              architectural PC
//   retire              pulse in the last cycle of each instruction
//   halt, halt_cause    sticky stop flag and cause (1 illegal, 2 misaligned,
//                       3 timeout)
// Optional build macro
//   MC_CORE_PERF_CNT_EN adds perf_cycles / perf_retired counters
// ============================================================================
module mc_cpu_core_hs #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned WAIT_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [31:0] pc_out,
    output logic        retire,
    output logic        halt,
`ifdef MC_CORE_PERF_CNT_EN
    output logic [31:0] perf_cycles,
    output logic [31:0] perf_retired,
`endif
    output logic [1:0]  halt_cause
);

    // ------------------------------------------------------------------
    // Encodings
    // ------------------------------------------------------------------
    localparam logic [5:0] c_op_rtype = 6'h00;
    localparam logic [5:0] c_op_j     = 6'h02;
    localparam logic [5:0] c_op_jal   = 6'h03;
    localparam logic [5:0] c_op_beq   = 6'h04;
    localparam logic [5:0] c_op_addiu = 6'h09;
    localparam logic [5:0] c_op_lui   = 6'h0F;
    localparam logic [5:0] c_op_lw    = 6'h23;
    localparam logic [5:0] c_op_sw    = 6'h2B;

    localparam logic [5:0] c_fn_jr    = 6'h08;
    localparam logic [5:0] c_fn_addu  = 6'h21;
    localparam logic [5:0] c_fn_subu  = 6'h23;
    localparam logic [5:0] c_fn_and   = 6'h24;
    localparam logic [5:0] c_fn_or    = 6'h25;
    localparam logic [5:0] c_fn_slt   = 6'h2A;

    localparam logic [1:0] c_cause_illegal = 2'd1;
    localparam logic [1:0] c_cause_align   = 2'd2;
    localparam logic [1:0] c_cause_timeout = 2'd3;

    localparam logic [31:0] c_wait_limit = WAIT_TIMEOUT[31:0];

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t      state_q, state_d;
    logic [31:0] pc_q,    pc_d;
    logic [31:0] ir_q,    ir_d;
    logic [31:0] mdr_q,   mdr_d;
    logic [31:0] a_q,     a_d;
    logic [31:0] b_q,     b_d;
    logic [31:0] alu_q,   alu_d;
    logic [1:0]  cause_q, cause_d;
    logic [31:0] wait_q,  wait_d;
    logic [31:0] rf_q [32];

    logic        w_rf_we;
    logic [4:0]  w_rf_waddr;
    logic [31:0] w_rf_wdata;

    // ------------------------------------------------------------------
    // Instruction fields
    // ------------------------------------------------------------------
    logic [5:0]  w_op, w_funct;
    logic [4:0]  w_rs, w_rt, w_rd;
    logic [31:0] w_sext;
    logic [31:0] w_jtarget;
    logic        w_is_r, w_is_jr, w_is_sw, w_legal;

    assign w_op      = ir_q[31:26];
    assign w_rs      = ir_q[25:21];
    assign w_rt      = ir_q[20:16];
    assign w_rd      = ir_q[15:11];
    assign w_funct   = ir_q[5:0];
    assign w_sext    = {{16{ir_q[15]}}, ir_q[15:0]};
    // pc_q already points past the jump when this is used
    assign w_jtarget = {pc_q[31:28], ir_q[25:0], 2'b00};
    assign w_is_r    = (w_op == c_op_rtype);
    assign w_is_jr   = w_is_r && (w_funct == c_fn_jr);
    assign w_is_sw   = (w_op == c_op_sw);

    always_comb begin
        w_legal = 1'b0;
        case (w_op)
            c_op_rtype: begin
                case (w_funct)
                    c_fn_jr, c_fn_addu, c_fn_subu,
                    c_fn_and, c_fn_or, c_fn_slt: w_legal = 1'b1;
                    default:                     w_legal = 1'b0;
                endcase
            end
            c_op_j, c_op_jal, c_op_beq, c_op_addiu,
            c_op_lui, c_op_lw, c_op_sw:          w_legal = 1'b1;
            default:                             w_legal = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Shared ALU, operands taken from the A/B temporaries and IR
    // ------------------------------------------------------------------
    logic [31:0] w_alu;

    always_comb begin
        w_alu = a_q + w_sext;
        if (w_is_r) begin
            case (w_funct)
                c_fn_addu: w_alu = a_q + b_q;
                c_fn_subu: w_alu = a_q - b_q;
                c_fn_and:  w_alu = a_q & b_q;
                c_fn_or:   w_alu = a_q | b_q;
                c_fn_slt:  w_alu = {31'd0, ($signed(a_q) < $signed(b_q))};
                default:   w_alu = a_q + b_q;
            endcase
        end else if (w_op == c_op_lui) begin
            w_alu = {ir_q[15:0], 16'h0000};
        end
    end

    // ------------------------------------------------------------------
    // Memory handshake and timeout
    // ------------------------------------------------------------------
    logic w_in_mem;
    logic w_stall;
    logic w_timeout;

    assign w_in_mem  = (state_q == S_FETCH) || (state_q == S_MEM);
    assign w_stall   = w_in_mem && !mem_ready;
    // Fires on the stalled cycle that brings the count up to the limit
    assign w_timeout = (c_wait_limit != 32'd0) && w_stall &&
                       ((wait_q + 32'd1) == c_wait_limit);

    // ------------------------------------------------------------------
    // Next-state / datapath control
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        mdr_d      = mdr_q;
        a_d        = a_q;
        b_d        = b_q;
        alu_d      = alu_q;
        cause_d    = cause_q;
        wait_d     = w_stall ? (wait_q + 32'd1) : 32'd0;
        w_rf_we    = 1'b0;
        w_rf_waddr = 5'd0;
        w_rf_wdata = 32'd0;

        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_q + 32'd4;
                    state_d = S_DECODE;
                end else if (w_timeout) begin
                    cause_d = c_cause_timeout;
                    state_d = S_HALT;
                end
            end

            S_DECODE: begin
                a_d = rf_q[w_rs];
                b_d = rf_q[w_rt];
                if (!w_legal) begin
                    cause_d = c_cause_illegal;
                    state_d = S_HALT;
                end else if (w_op == c_op_j) begin
                    pc_d    = w_jtarget;
                    state_d = S_FETCH;
                end else if (w_op == c_op_jal) begin
                    pc_d       = w_jtarget;
                    w_rf_we    = 1'b1;
                    w_rf_waddr = 5'd31;
                    w_rf_wdata = pc_q;
                    state_d    = S_FETCH;
                end else begin
                    state_d = S_EXEC;
                end
            end

            S_EXEC: begin
                if (w_is_jr) begin
                    pc_d    = a_q;
                    state_d = S_FETCH;
                end else if (w_op == c_op_beq) begin
                    if (a_q == b_q) begin
                        pc_d = pc_q + {w_sext[29:0], 2'b00};
                    end
                    state_d = S_FETCH;
                end else if ((w_op == c_op_lw) || w_is_sw) begin
                    alu_d = w_alu;
                    if (w_alu[1:0] != 2'b00) begin
                        cause_d = c_cause_align;
                        state_d = S_HALT;
                    end else begin
                        state_d = S_MEM;
                    end
                end else begin
                    alu_d   = w_alu;
                    state_d = S_WB;
                end
            end

            S_MEM: begin
                if (mem_ready) begin
                    if (w_is_sw) begin
                        state_d = S_FETCH;
                    end else begin
                        mdr_d   = mem_rdata;
                        state_d = S_WB;
                    end
                end else if (w_timeout) begin
                    cause_d = c_cause_timeout;
                    state_d = S_HALT;
                end
            end

            S_WB: begin
                w_rf_we = 1'b1;
                if (w_is_r) begin
                    w_rf_waddr = w_rd;
                    w_rf_wdata = alu_q;
                end else if (w_op == c_op_lw) begin
                    w_rf_waddr = w_rt;
                    w_rf_wdata = mdr_q;
                end else begin
                    w_rf_waddr = w_rt;
                    w_rf_wdata = alu_q;
                end
                state_d = S_FETCH;
            end

            S_HALT: begin
                state_d = S_HALT;
            end

            // Unused encodings park the core rather than run on garbage
            default: begin
                state_d = S_HALT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= 32'd0;
            mdr_q   <= 32'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            alu_q   <= 32'd0;
            cause_q <= 2'd0;
            wait_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            mdr_q   <= mdr_d;
            a_q     <= a_d;
            b_q     <= b_d;
            alu_q   <= alu_d;
            cause_q <= cause_d;
            wait_q  <= wait_d;
        end
    end

    // $0 is never written, so it reads as its reset value of zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= 32'd0;
            end
        end else if (w_rf_we && (w_rf_waddr != 5'd0)) begin
            rf_q[w_rf_waddr] <= w_rf_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    logic w_retire;

    // The last cycle of an instruction is the one that hands back to FETCH.
    // For sw that is the cycle the store is accepted, so it follows mem_ready.
    assign w_retire = (state_q != S_FETCH) && (state_q != S_HALT) &&
                      (state_d == S_FETCH);

    // Gating with reset drops the request the moment reset is asserted and
    // keeps it low while reset is held, even though state sits in FETCH.
    assign mem_req    = w_in_mem && !reset;
    assign mem_we     = (state_q == S_MEM) && w_is_sw && !reset;
    assign mem_addr   = mem_req ? ((state_q == S_FETCH) ? pc_q : alu_q) : 32'd0;
    assign mem_wdata  = mem_we ? b_q : 32'd0;
    assign pc_out     = pc_q;
    assign retire     = w_retire;
    assign halt       = (state_q == S_HALT);
    assign halt_cause = cause_q;

`ifdef MC_CORE_PERF_CNT_EN
    logic [31:0] perf_cycles_q;
    logic [31:0] perf_retired_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_cycles_q  <= 32'd0;
            perf_retired_q <= 32'd0;
        end else begin
            if (state_q != S_HALT) begin
                perf_cycles_q <= perf_cycles_q + 32'd1;
            end
            if (w_retire) begin
                perf_retired_q <= perf_retired_q + 32'd1;
            end
        end
    end

    assign perf_cycles  = perf_cycles_q;
    assign perf_retired = perf_retired_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mc_cpu_core_hs.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_mc_cpu_core_hs
// Purpose  : Directed self-checking bench for mc_cpu_core_hs. A word memory
//            with configurable wait states answers the core; short hand-
//            assembled programs cover ALU ops, wait-state stores/loads,
//            branches and jumps, the three trap causes and mid-request reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mc_cpu_core_hs;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_req, mem_we, retire, halt;
    logic [31:0] mem_addr, mem_wdata, pc_out;
    logic [1:0]  halt_cause;
`ifdef MC_CORE_PERF_CNT_EN
    logic [31:0] perf_cycles, perf_retired;
`endif

    mc_cpu_core_hs #(
        .RESET_PC     (32'h0000_0000),
        .WAIT_TIMEOUT (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_ready    (mem_ready),
        .mem_rdata    (mem_rdata),
        .pc_out       (pc_out),
        .retire       (retire),
        .halt         (halt),
`ifdef MC_CORE_PERF_CNT_EN
        .perf_cycles  (perf_cycles),
        .perf_retired (perf_retired),
`endif
        .halt_cause   (halt_cause)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Memory model: 256 words, 'waits' stall cycles before each ready
    // ------------------------------------------------------------------
    logic [31:0] mem [0:255];
    int          waits = 0;
    bit          stuck = 1'b0;
    int          wcnt  = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (mem_req && !stuck) begin
                if (wcnt >= waits) begin
                    mem_ready = 1'b1;
                    mem_rdata = mem[mem_addr[9:2]];
                    if (mem_we) mem[mem_addr[9:2]] = mem_wdata;
                    wcnt = 0;
                end else begin
                    mem_ready = 1'b0;
                    wcnt++;
                end
            end else begin
                mem_ready = 1'b0;
                wcnt = 0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Cycle stepping: sample mid-cycle, after the negedge response settles
    // ------------------------------------------------------------------
    int          cyc, rcnt, reqseen, swcnt;
    int          rcyc [8];
    logic [63:0] rmask;

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
            cyc++;
            if (retire) begin
                if (rcnt < 8) rcyc[rcnt] = cyc;
                if (cyc < 64) rmask[cyc] = 1'b1;
                rcnt++;
            end
            if (mem_req) reqseen++;
            if (mem_req && mem_we && (mem_addr == 32'h80) &&
                (mem_wdata == 32'hDEADBEEF)) swcnt++;
        end
    endtask

    task automatic hold_rst();
        reset = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    endtask

    // Release between posedge and negedge so cycle 1 is a full FETCH cycle
    task automatic release_rst(input int w, input bit s);
        waits = w;
        stuck = s;
        @(posedge clk);
        #2;
        reset   = 1'b0;
        cyc     = 0;
        rcnt    = 0;
        rmask   = '0;
        reqseen = 0;
        swcnt   = 0;
        for (int i = 0; i < 8; i++) rcyc[i] = 0;
    endtask

    initial begin
        // ---------------- reset state + ALU program, zero wait ----------
        hold_rst();
        mem[0] = 32'h2401_0005;   // addiu $1,$0,5
        mem[1] = 32'h2402_FFFD;   // addiu $2,$0,-3
        mem[2] = 32'h0022_1821;   // addu  $3,$1,$2
        mem[3] = 32'h0041_202A;   // slt   $4,$2,$1
        mem[4] = 32'h0800_0004;   // j     0x10
        @(posedge clk);
        #2;
        check_val("rst_mem_req",  {31'd0, mem_req}, 32'd0);
        check_val("rst_mem_we",   {31'd0, mem_we},  32'd0);
        check_val("rst_mem_addr", mem_addr,  32'd0);
        check_val("rst_wdata",    mem_wdata, 32'd0);
        check_val("rst_pc",       pc_out,    32'd0);
        check_val("rst_flags",    {29'd0, retire, halt, halt_cause[0]}, 32'd0);
        check_val("rst_cause",    {30'd0, halt_cause}, 32'd0);
        release_rst(0, 1'b0);
        step(16);
        check_val("alu_retire_mask", rmask[31:0], 32'h0001_1110);
        step(1);
        check_val("alu_pc",  pc_out, 32'd16);
        check_val("alu_r3",  dut.rf_q[3], 32'd2);
        check_val("alu_r4",  dut.rf_q[4], 32'd1);
        check_val("alu_r2",  dut.rf_q[2], 32'hFFFF_FFFD);
`ifdef MC_CORE_PERF_CNT_EN
        check_val("perf_cycles",  perf_cycles,  32'd16);
        check_val("perf_retired", perf_retired, 32'd4);
`endif

        // ---------------- sw/lw with 3 wait cycles ----------------------
        hold_rst();
        mem[0] = 32'h3C01_DEAE;   // lui   $1,0xDEAE
        mem[1] = 32'h2421_BEEF;   // addiu $1,$1,0xBEEF
        mem[2] = 32'hAC01_0080;   // sw    $1,0x80($0)
        mem[3] = 32'h8C05_0080;   // lw    $5,0x80($0)
        mem[4] = 32'h0800_0004;   // j     0x10
        release_rst(3, 1'b0);
        step(40);
        check_val("ws_first_retire", rcyc[0], 32'd7);
        check_val("ws_second_retire", rcyc[1], 32'd14);
        check_val("ws_sw_cycles", rcyc[2] - rcyc[1], 32'd10);
        check_val("ws_lw_cycles", rcyc[3] - rcyc[2], 32'd11);
        check_val("ws_sw_hold", swcnt, 32'd4);
        check_val("ws_mem_word", mem[32], 32'hDEAD_BEEF);
        check_val("ws_r5", dut.rf_q[5], 32'hDEAD_BEEF);

        // ---------------- beq taken, imm = -1 at 0x20 -------------------
        hold_rst();
        mem[0] = 32'h0800_0008;   // j   0x20
        mem[8] = 32'h1000_FFFF;   // beq $0,$0,-1
        release_rst(0, 1'b0);
        step(6);
        check_val("beq_pc_first", pc_out, 32'h20);
        step(3);
        check_val("beq_pc_loop", pc_out, 32'h20);
        check_val("beq_retires", rcnt, 32'd3);

        // ---------------- beq not taken, j, jal, jr, illegal ------------
        hold_rst();
        mem[0]  = 32'h2401_0001;  // addiu $1,$0,1
        mem[1]  = 32'h1020_FFFF;  // beq   $1,$0,-1 (not taken)
        mem[2]  = 32'h0800_0010;  // j     0x40
        mem[16] = 32'h0C00_0040;  // jal   0x100
        mem[64] = 32'h03E0_0008;  // jr    $31
        mem[17] = 32'hFC00_0000;  // opcode 0x3F
        release_rst(0, 1'b0);
        step(8);
        check_val("bnt_pc", pc_out, 32'h08);
        step(4);
        check_val("jal_pc", pc_out, 32'h100);
        check_val("jal_r31", dut.rf_q[31], 32'h44);
        step(3);
        check_val("jr_pc", pc_out, 32'h44);
        step(2);
        check_val("ill_halt",  {31'd0, halt}, 32'd1);
        check_val("ill_cause", {30'd0, halt_cause}, 32'd1);
        check_val("ill_pc",    pc_out, 32'h48);
        reqseen = 0;
        step(6);
        check_val("ill_hold_halt", {31'd0, halt}, 32'd1);
        check_val("ill_hold_cause", {30'd0, halt_cause}, 32'd1);
        check_val("ill_no_req", reqseen, 32'd0);
        check_val("ill_retires", rcnt, 32'd5);

        // ---------------- misaligned lw ---------------------------------
        hold_rst();
        mem[0] = 32'h8C05_0006;   // lw $5,6($0)
        release_rst(0, 1'b0);
        step(4);
        check_val("mis_halt",  {31'd0, halt}, 32'd1);
        check_val("mis_cause", {30'd0, halt_cause}, 32'd2);
        check_val("mis_pc",    pc_out, 32'h04);
        reqseen = 0;
        step(5);
        check_val("mis_no_req", reqseen, 32'd0);
        check_val("mis_hold_cause", {30'd0, halt_cause}, 32'd2);
        check_val("mis_retires", rcnt, 32'd0);

        // ---------------- timeout, mem_ready stuck low ------------------
        hold_rst();
        release_rst(0, 1'b1);
        step(4);
        check_val("to_not_yet", {31'd0, halt}, 32'd0);
        check_val("to_req_up",  {31'd0, mem_req}, 32'd1);
        step(1);
        check_val("to_halt",  {31'd0, halt}, 32'd1);
        check_val("to_cause", {30'd0, halt_cause}, 32'd3);
        check_val("to_req_down", {31'd0, mem_req}, 32'd0);
        step(3);
        check_val("to_hold_cause", {30'd0, halt_cause}, 32'd3);
        check_val("to_pc", pc_out, 32'd0);

        // ---------------- reset in the middle of a request --------------
        hold_rst();
        mem[0] = 32'h2401_0005;
        mem[1] = 32'h2402_FFFD;
        release_rst(3, 1'b0);
        step(9);
        check_val("mid_req_up", {31'd0, mem_req}, 32'd1);
        check_val("mid_pc_pre", pc_out, 32'd4);
        #2;
        reset = 1'b1;
        #1;
        check_val("mid_req_drop", {31'd0, mem_req}, 32'd0);
        check_val("mid_pc_rst",   pc_out, 32'd0);
        check_val("mid_addr_rst", mem_addr, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
